rx_port_arbiter: RTL and testbench

- Shares the router local input port between NUM_PORTS MAC receive adapters. Each adapter presents 70-bit flits with a val/ack handshake.
- Grants one adapter at a time in round-robin order and holds the grant for the whole packet, from header flit to tail flit.
- Forwards the granted adapter's flits to the router and routes the router's ack back to that adapter only.
- A watchdog releases a grant whose owner has stopped sending flits part-way through a packet.

---
 rtl/rx_port_arbiter_if.sv | 27 ++
 rtl/rx_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_rx_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_port_arbiter_if.sv
// Adapter-side and router-side signals of the receive port arbiter.
// The arbiter connects through the slave modport; the environment drives through the master modport.
interface rx_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 70
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]            req_val;
  logic [NUM_PORTS-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]           data_router;
  logic                            val;
  logic                            ack;
  logic [NUM_PORTS-1:0]            grant;
  logic                            busy;
  logic                            err_timeout;
  logic                            err_orphan;

  modport master (
    output req_data, req_val, ack,
    input  req_ack, data_router, val, grant, busy, err_timeout, err_orphan
  );

  modport slave (
    input  req_data, req_val, ack,
    output req_ack, data_router, val, grant, busy, err_timeout, err_orphan
  );
endinterface

// File: rtl/rx_port_arbiter.sv
// Round-robin, packet-locked arbiter that shares the router local input port
// between NUM_PORTS MAC receive adapters, with an idle watchdog and orphan-flit flush.
module rx_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 70,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  rx_port_arbiter_if.slave   bus
);
  localparam int unsigned NP        = NUM_PORTS;
  localparam int          PW        = $clog2(NUM_PORTS);
  localparam int          HDR_BIT   = DATA_WIDTH - 1;
  localparam int          TAIL_BIT  = DATA_WIDTH - 2;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [15:0]          wd_q, wd_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_orphan_q, err_orphan_d;

  logic [DATA_WIDTH-1:0] flit [NUM_PORTS];
  logic [NUM_PORTS-1:0]  hdr_req, orphan;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_val;
  logic [PW-1:0]         sel_idx;
  logic [PW-1:0]         win_idx;
  logic                  win_found;
  int unsigned           rr_idx;

  always_comb begin : unpack
    hdr_req = '0;
    orphan  = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      flit[i]    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      hdr_req[i] = bus.req_val[i] & flit[i][HDR_BIT];
      orphan[i]  = bus.req_val[i] & ~flit[i][HDR_BIT];
    end
  end

  always_comb begin : select
    sel_data = '0;
    sel_val  = 1'b0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (grant_q[i]) begin
        sel_data = flit[i];
        sel_val  = bus.req_val[i];
        sel_idx  = PW'(i);
      end
    end
  end

  // Search starts just after the last winner so every port gets a turn.
  always_comb begin : round_robin
    win_found = 1'b0;
    win_idx   = ptr_q;
    rr_idx    = 0;
    for (int unsigned off = 1; off <= NP; off++) begin
      rr_idx = (32'(ptr_q) + off) % NP;
      if (!win_found && hdr_req[PW'(rr_idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(rr_idx);
      end
    end
  end

  always_comb begin : fsm
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    wd_d            = wd_q;
    err_timeout_d   = 1'b0;
    err_orphan_d    = 1'b0;
    bus.val         = 1'b0;
    bus.data_router = '0;
    bus.req_ack     = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ack  = orphan;
        err_orphan_d = |orphan;
        if (win_found) begin
          state_d = LOCK;
          grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
          wd_d    = '0;
        end
      end
      LOCK: begin
        bus.val         = sel_val;
        bus.data_router = sel_data;
        bus.req_ack     = grant_q & {NUM_PORTS{bus.ack}};
        if (sel_val && bus.ack && sel_data[TAIL_BIT]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_idx;
          wd_d    = '0;
        end else if (sel_val) begin
          wd_d = '0;
        end else if (wd_q + 16'd1 == TIMEOUT_W) begin
          // Abort on the TIMEOUT-th idle cycle; val is low so nothing is in flight.
          state_d       = IDLE;
          grant_d       = '0;
          ptr_d         = sel_idx;
          wd_d          = '0;
          err_timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
    endcase
    if (rst) begin
      bus.val         = 1'b0;
      bus.data_router = '0;
      bus.req_ack     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= PW'(NUM_PORTS - 1);
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
      err_orphan_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q == LOCK);
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_orphan  = err_orphan_q;
endmodule

// File: tb/tb_rx_port_arbiter.sv
// Scoreboard bench for rx_port_arbiter: expected router-side flits are queued in
// hand-computed order and a negedge monitor checks every val && ack transfer.
module tb_rx_port_arbiter;
  localparam int NP = 4;
  localparam int DW = 70;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  rx_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int              port;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_xfer = 0;
  int   n_tmo  = 0;
  int   n_orph = 0;
  int   x0, t0, o0;
  logic [NP-1:0] mon_g;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic h, input logic t, input int p,
                                       input int tag, input int i);
    logic [DW-1:0] f;
    f          = '0;
    f[DW-1]    = h;
    f[DW-2]    = t;
    f[15:0]    = 16'(i);
    f[31:16]   = 16'(tag);
    f[39:32]   = 8'(p);
    f[60:40]   = 21'h1A5A5;
    return f;
  endfunction

  function automatic logic [DW-1:0] pkt_flit(input int p, input int n, input int tag, input int i);
    return mk(i == 0, i == n - 1, p, tag, i);
  endfunction

  task automatic drive(input int p, input logic v, input logic [DW-1:0] f);
    bus.req_data[p*DW +: DW] = f;
    bus.req_val[p]           = v;
  endtask

  task automatic send_flit(input int p, input logic [DW-1:0] f);
    bit done = 1'b0;
    drive(p, 1'b1, f);
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      done = bus.req_ack[p];
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_wait: port %0d got no req_ack, expected one within 1000 cycles", p);
    end
    drive(p, 1'b0, '0);
  endtask

  task automatic send_pkt(input int p, input int n, input int tag);
    for (int i = 0; i < n; i++) send_flit(p, pkt_flit(p, n, tag, i));
  endtask

  task automatic exp_pkt(input int p, input int n, input int tag);
    for (int i = 0; i < n; i++) expq.push_back('{p, pkt_flit(p, n, tag, i)});
  endtask

  always @(negedge clk) begin
    if (bus.err_timeout === 1'b1) n_tmo++;
    if (bus.err_orphan === 1'b1) n_orph++;
    if (bus.val === 1'b1 && bus.ack === 1'b1) begin
      n_xfer++;
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got %h expected no transfer", bus.data_router);
      end else begin
        mon_e = expq.pop_front();
        mon_g = '0;
        mon_g[mon_e.port] = 1'b1;
        chk("xfer_data", bus.data_router, mon_e.data);
        chk("xfer_grant", DW'(bus.grant), DW'(mon_g));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.ack      = 1'b0;
    bus.req_val  = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", DW'(bus.grant), '0);
    chk("rst_busy", DW'(bus.busy), '0);
    chk("rst_val", DW'(bus.val), '0);
    chk("rst_data", bus.data_router, '0);
    chk("rst_req_ack", DW'(bus.req_ack), '0);
    chk("rst_err_timeout", DW'(bus.err_timeout), '0);
    chk("rst_err_orphan", DW'(bus.err_orphan), '0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.ack = 1'b1;

    // Single port, four-flit packet.
    exp_pkt(0, 4, 1);
    x0 = n_xfer;
    fork
      send_pkt(0, 4, 1);
      begin
        @(negedge clk);
        chk("t1_grant_seen", DW'(bus.grant), '0);
        @(negedge clk);
        chk("t1_grant_lock", DW'(bus.grant), DW'(4'b0001));
        chk("t1_busy_lock", DW'(bus.busy), DW'(1'b1));
      end
    join
    @(negedge clk);
    chk("t1_xfers", DW'(n_xfer - x0), DW'(4));
    chk("t1_busy_after", DW'(bus.busy), '0);
    chk("t1_grant_after", DW'(bus.grant), '0);
    @(posedge clk);
    #1;

    // Contention: port 1 then port 2 (ptr=0), then port 1 again (ptr=2).
    exp_pkt(1, 3, 2);
    exp_pkt(2, 2, 2);
    fork
      send_pkt(1, 3, 2);
      send_pkt(2, 2, 2);
    join
    exp_pkt(1, 2, 3);
    exp_pkt(2, 2, 3);
    fork
      send_pkt(1, 2, 3);
      send_pkt(2, 2, 3);
    join
    @(negedge clk);
    chk("t2_queue_empty", DW'(expq.size()), '0);
    @(posedge clk);
    #1;

    // Backpressure longer than TIMEOUT with req_val held high.
    exp_pkt(0, 4, 4);
    x0 = n_xfer;
    t0 = n_tmo;
    fork
      send_pkt(0, 4, 4);
      begin
        for (int c = 0; c < 100 && n_xfer < x0 + 2; c++) begin
          @(posedge clk);
          #1;
        end
        chk("t3_two_moved", DW'(n_xfer - x0), DW'(2));
        bus.ack = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_stall", DW'(bus.busy), DW'(1'b1));
        chk("t3_grant_stall", DW'(bus.grant), DW'(4'b0001));
        chk("t3_val_stall", DW'(bus.val), DW'(1'b1));
        repeat (150) @(posedge clk);
        #1;
        bus.ack = 1'b1;
      end
    join
    @(negedge clk);
    chk("t3_no_timeout", DW'(n_tmo - t0), '0);
    chk("t3_queue_empty", DW'(expq.size()), '0);
    chk("t3_busy_after", DW'(bus.busy), '0);
    @(posedge clk);
    #1;

    // Watchdog: port 1 goes silent after its header.
    t0 = n_tmo;
    o0 = n_orph;
    expq.push_back('{1, pkt_flit(1, 3, 5, 0)});
    send_flit(1, pkt_flit(1, 3, 5, 0));
    repeat (254) @(posedge clk);
    @(negedge clk);
    chk("t4_busy_before", DW'(bus.busy), DW'(1'b1));
    chk("t4_tmo_before", DW'(bus.err_timeout), '0);
    @(negedge clk);
    chk("t4_tmo_pulse", DW'(bus.err_timeout), DW'(1'b1));
    chk("t4_busy_abort", DW'(bus.busy), '0);
    chk("t4_grant_abort", DW'(bus.grant), '0);
    @(negedge clk);
    chk("t4_tmo_one_cycle", DW'(bus.err_timeout), '0);
    @(posedge clk);
    #1;
    // Orphan body flit on port 1 while port 2 presents a header.
    exp_pkt(2, 2, 6);
    drive(1, 1'b1, pkt_flit(1, 3, 5, 1));
    drive(2, 1'b1, pkt_flit(2, 2, 6, 0));
    @(negedge clk);
    chk("t4_orphan_ack", DW'(bus.req_ack), DW'(4'b0010));
    chk("t4_orphan_val", DW'(bus.val), '0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, '0);
    @(negedge clk);
    chk("t4_orphan_pulse", DW'(bus.err_orphan), DW'(1'b1));
    chk("t4_grant_p2", DW'(bus.grant), DW'(4'b0100));
    @(posedge clk);
    #1;
    send_flit(2, pkt_flit(2, 2, 6, 1));
    @(negedge clk);
    chk("t4_tmo_count", DW'(n_tmo - t0), DW'(1));
    chk("t4_orphan_count", DW'(n_orph - o0), DW'(1));
    @(posedge clk);
    #1;

    // Single-flit packet on port 3, then ptr=3 makes port 0 beat port 3.
    x0 = n_xfer;
    expq.push_back('{3, mk(1'b1, 1'b1, 3, 7, 0)});
    send_flit(3, mk(1'b1, 1'b1, 3, 7, 0));
    @(negedge clk);
    chk("t5_busy_after", DW'(bus.busy), '0);
    chk("t5_grant_after", DW'(bus.grant), '0);
    chk("t5_one_xfer", DW'(n_xfer - x0), DW'(1));
    @(posedge clk);
    #1;
    expq.push_back('{0, mk(1'b1, 1'b1, 0, 8, 0)});
    expq.push_back('{3, mk(1'b1, 1'b1, 3, 8, 0)});
    fork
      send_flit(0, mk(1'b1, 1'b1, 0, 8, 0));
      send_flit(3, mk(1'b1, 1'b1, 3, 8, 0));
    join
    @(negedge clk);
    chk("t5_queue_empty", DW'(expq.size()), '0);
    @(posedge clk);
    #1;

    // Reset during LOCK.
    expq.push_back('{0, pkt_flit(0, 2, 9, 0)});
    send_flit(0, pkt_flit(0, 2, 9, 0));
    drive(0, 1'b1, pkt_flit(0, 2, 9, 1));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_val", DW'(bus.val), '0);
    chk("t6_rst_req_ack", DW'(bus.req_ack), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, '0);
    @(negedge clk);
    chk("t6_grant_after", DW'(bus.grant), '0);
    chk("t6_busy_after", DW'(bus.busy), '0);
    chk("t6_val_after", DW'(bus.val), '0);
    @(posedge clk);
    #1;
    exp_pkt(0, 2, 10);
    fork
      send_pkt(0, 2, 10);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6_regrant", DW'(bus.grant), DW'(4'b0001));
      end
    join
    @(negedge clk);
    chk("final_queue_empty", DW'(expq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
